func_arbiter: RTL and testbench

- Shares one cube(a)+sqrt(b) unit (`func`) between two requesters.
- Round-robin arbitration; accepts one operand pair at a time and sequences the unit's start/busy protocol.
- Captures the result and returns it with the requester id over a valid/ready response channel.
- Sits between the request sources and the single `func` instance; drives its start_i, a_i and b_i, and reads its busy_o and y_o.

---
 rtl/func_arbiter_if.sv | 38 +++
 rtl/func_arbiter.sv | 146 ++++++++++++++
 tb/tb_func_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/func_arbiter_if.sv
// Request/response bundle between two operand sources, the arbiter and the response consumer.
// master = environment side, slave = arbiter side.
interface func_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int RES_W  = 16
);
    logic              req0_valid;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              req1_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [RES_W-1:0]  rsp_y;
    logic              rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_y, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_y, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/func_arbiter.sv
// Round-robin arbiter sharing one cube(a)+sqrt(b) unit between two requesters,
// with a run timeout and a valid/ready response channel.
//
// state | meaning
// IDLE  | waiting for a request; grants combinationally
// START | one-cycle start pulse to the unit
// RUN   | waiting for busy to rise and fall, or for the timeout
// RESP  | response held until the consumer takes it
module func_arbiter #(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    func_arbiter_if.slave     bus,
    output logic              unit_start_o,
    output logic [DATA_W-1:0] unit_a_o,
    output logic [DATA_W-1:0] unit_b_o,
    input  logic [1:0]        unit_busy_i,
    input  logic [RES_W-1:0]  unit_y_i
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               seen_busy_q, seen_busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  op_a_q, op_a_d;
    logic [DATA_W-1:0]  op_b_q, op_b_d;
    logic               id_q, id_d;
    logic [RES_W-1:0]   rsp_y_q, rsp_y_d;
    logic               rsp_err_q, rsp_err_d;
    logic               grant0, grant1;
    logic               busy;

    assign busy = |unit_busy_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            seen_busy_q  <= 1'b0;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            id_q         <= 1'b0;
            rsp_y_q      <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            seen_busy_q  <= seen_busy_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            id_q         <= id_d;
            rsp_y_q      <= rsp_y_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        seen_busy_d  = seen_busy_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        id_d         = id_q;
        rsp_y_d      = rsp_y_q;
        rsp_err_d    = rsp_err_q;
        grant0       = 1'b0;
        grant1       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // On a tie the requester that did not win last time goes first.
                if (bus.req0_valid && (!bus.req1_valid || last_grant_q)) begin
                    grant0 = 1'b1;
                end else if (bus.req1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0) begin
                    op_a_d       = bus.req0_a;
                    op_b_d       = bus.req0_b;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = S_START;
                end else if (grant1) begin
                    op_a_d       = bus.req1_a;
                    op_b_d       = bus.req1_b;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = S_START;
                end
            end
            S_START: begin
                seen_busy_d = 1'b0;
                cnt_d       = '0;
                state_d     = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (busy) begin
                    seen_busy_d = 1'b1;
                end
                // Completion wins over a timeout landing in the same cycle.
                if (seen_busy_q && !busy) begin
                    rsp_y_d   = unit_y_i;
                    rsp_err_d = 1'b0;
                    state_d   = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_y_d   = '0;
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_y      = rsp_y_q;
    assign bus.rsp_err    = rsp_err_q;
    assign unit_start_o   = (state_q == S_START);
    assign unit_a_o       = op_a_q;
    assign unit_b_o       = op_b_q;

endmodule

// File: tb/tb_func_arbiter.sv
// Bench for func_arbiter: behavioural unit model, directed table, corner sequences and random traffic.
module tb_func_arbiter;
    localparam int DW  = 8;
    localparam int RW  = 16;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          unit_start;
    logic [DW-1:0] unit_a, unit_b;
    logic [1:0]    unit_busy;
    logic [RW-1:0] unit_y;

    always #5 clk = ~clk;

    func_arbiter_if #(.DATA_W(DW), .RES_W(RW)) bus ();

    func_arbiter #(.DATA_W(DW), .RES_W(RW), .TIMEOUT(TMO)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .unit_start_o(unit_start),
        .unit_a_o    (unit_a),
        .unit_b_o    (unit_b),
        .unit_busy_i (unit_busy),
        .unit_y_i    (unit_y)
    );

    function automatic int unsigned ref_y(input int unsigned a, input int unsigned b);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= b) r++;
        return a * a * a + r;
    endfunction

    // Unit model: busy for u_k cycles starting the cycle after start; u_stuck forces busy forever.
    int            u_cnt   = 0;
    int            u_k     = 0;
    bit            u_stuck = 1'b0;
    logic [RW-1:0] u_y_q   = '0;

    always @(posedge clk) begin
        if (rst) begin
            u_cnt <= 0;
            u_y_q <= '0;
        end else if (unit_start) begin
            u_cnt <= u_k;
            u_y_q <= RW'(ref_y(32'(unit_a), 32'(unit_b)));
        end else if (u_cnt > 0) begin
            u_cnt <= u_cnt - 1;
        end
    end
    assign unit_busy = u_stuck ? 2'b01 : ((u_cnt != 0) ? 2'b10 : 2'b00);
    assign unit_y    = u_y_q;

    int n_chk  = 0;
    int n_pass = 0;
    bit lg     = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    endtask

    task automatic drive(input bit v0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                         input bit v1, input logic [DW-1:0] a1, input logic [DW-1:0] b1);
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
    endtask

    // Called at posedge+1 of an IDLE cycle with requests already driven; returns at posedge+1 of the next IDLE cycle.
    task automatic run_txn(input string nm, input bit eid, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                           input logic [RW-1:0] ey, input bit eerr, input int k, input int hold);
        int lat, exp_lat, starts;
        bit stable, quiet, held;
        u_k     = k;
        exp_lat = (k == 0 || k + 1 > TMO) ? TMO + 2 : k + 3;
        @(negedge clk);
        chk({nm, ".ready0"}, 32'(bus.req0_ready), 32'(eid == 1'b0));
        chk({nm, ".ready1"}, 32'(bus.req1_ready), 32'(eid == 1'b1));
        tick();
        @(negedge clk);
        starts = unit_start ? 1 : 0;
        chk({nm, ".op_a"}, 32'(unit_a), 32'(ea));
        chk({nm, ".op_b"}, 32'(unit_b), 32'(eb));
        lat    = 1;
        stable = 1'b1;
        quiet  = 1'b1;
        while (!bus.rsp_valid && lat < 100) begin
            if (bus.req0_ready || bus.req1_ready) quiet = 1'b0;
            tick();
            lat++;
            @(negedge clk);
            if (unit_start) starts++;
            if (!bus.rsp_valid && (unit_a !== ea || unit_b !== eb)) stable = 1'b0;
        end
        chk({nm, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, ".starts"}, 32'(starts), 32'd1);
        chk({nm, ".ops_stable"}, 32'(stable), 32'd1);
        chk({nm, ".no_ready_busy"}, 32'(quiet), 32'd1);
        chk({nm, ".id"}, 32'(bus.rsp_id), 32'(eid));
        chk({nm, ".y"}, 32'(bus.rsp_y), 32'(ey));
        chk({nm, ".err"}, 32'(bus.rsp_err), 32'(eerr));
        held = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== ey || bus.rsp_id !== eid ||
                bus.rsp_err !== eerr || bus.req0_ready || bus.req1_ready) held = 1'b0;
        end
        if (hold > 0) chk({nm, ".held"}, 32'(held), 32'd1);
        tick();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk({nm, ".handshake"}, 32'({bus.rsp_valid, bus.req0_ready, bus.req1_ready}), 32'(3'b100));
        tick();
        bus.rsp_ready = 1'b0;
        chk({nm, ".idle_after"}, 32'(bus.rsp_valid), 32'd0);
        lg = eid;
    endtask

    typedef struct {
        string         nm;
        bit            v0;
        logic [DW-1:0] a0, b0;
        bit            v1;
        logic [DW-1:0] a1, b1;
        int            k;
        int            hold;
        bit            eid;
        logic [RW-1:0] ey;
        bit            eerr;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{"single",       1'b1, 8'd2,  8'd9,  1'b0, 8'd0, 8'd0,  3, 0, 1'b0, 16'd11,   1'b0};
        tbl[1] = '{"backpressure", 1'b0, 8'd0,  8'd0,  1'b1, 8'd3, 8'd16, 2, 4, 1'b1, 16'd31,   1'b0};
        tbl[2] = '{"max_ops",      1'b1, 8'd15, 8'd15, 1'b0, 8'd0, 8'd0,  4, 1, 1'b0, 16'd3378, 1'b0};
        tbl[3] = '{"no_busy",      1'b0, 8'd0,  8'd0,  1'b1, 8'd7, 8'd1,  0, 0, 1'b1, 16'd0,    1'b1};

        rst           = 1'b1;
        bus.rsp_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (3) tick();
        rst = 1'b0;
        chk("reset.ctrl", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_id, unit_start, bus.req0_ready, bus.req1_ready}), 32'd0);
        chk("reset.ops", 32'({unit_a, unit_b}), 32'd0);
        chk("reset.y", 32'(bus.rsp_y), 32'd0);

        // Both valid continuously: 0, 1, then 0 again.
        drive(1'b1, 8'd1, 8'd4, 1'b1, 8'd4, 8'd0);
        run_txn("simul.first",  1'b0, 8'd1, 8'd4, 16'd3,  1'b0, 2, 0);
        run_txn("simul.second", 1'b1, 8'd4, 8'd0, 16'd64, 1'b0, 3, 0);
        run_txn("simul.third",  1'b0, 8'd1, 8'd4, 16'd3,  1'b0, 1, 0);
        drive(1'b0, '0, '0, 1'b0, '0, '0);

        for (int i = 0; i < 4; i++) begin
            drive(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1);
            run_txn(tbl[i].nm, tbl[i].eid,
                    tbl[i].eid ? tbl[i].a1 : tbl[i].a0, tbl[i].eid ? tbl[i].b1 : tbl[i].b0,
                    tbl[i].ey, tbl[i].eerr, tbl[i].k, tbl[i].hold);
            drive(1'b0, '0, '0, 1'b0, '0, '0);
        end

        // Busy stuck high: exactly TMO RUN cycles then an error response.
        u_stuck = 1'b1;
        drive(1'b1, 8'd6, 8'd6, 1'b0, '0, '0);
        run_txn("timeout", 1'b0, 8'd6, 8'd6, 16'd0, 1'b1, 0, 0);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        u_stuck = 1'b0;
        tick();

        // Reset while the unit is busy: operation dropped, no response.
        drive(1'b1, 8'd5, 8'd5, 1'b0, '0, '0);
        u_k = 10;
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lg  = 1'b1;
        chk("midrst.ctrl", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_id, unit_start, bus.req0_ready, bus.req1_ready}), 32'd0);
        chk("midrst.ops", 32'({unit_a, unit_b}), 32'd0);
        chk("midrst.y", 32'(bus.rsp_y), 32'd0);
        begin
            bit silent = 1'b1;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                if (bus.rsp_valid || unit_start) silent = 1'b0;
                tick();
            end
            chk("midrst.silent", 32'(silent), 32'd1);
        end
        drive(1'b1, 8'd0, 8'd0, 1'b0, '0, '0);
        run_txn("after_rst", 1'b0, 8'd0, 8'd0, 16'd0, 1'b0, 2, 0);
        drive(1'b0, '0, '0, 1'b0, '0, '0);

        // Random traffic against the rule-level model.
        for (int it = 0; it < 40; it++) begin
            int            idle, p, k, hold;
            bit            v0, v1, eid, eerr, quiet;
            logic [DW-1:0] a0, b0, a1, b1, ea, eb;
            logic [RW-1:0] ey;
            idle  = $urandom_range(0, 2);
            quiet = 1'b1;
            for (int c = 0; c < idle; c++) begin
                @(negedge clk);
                if (bus.req0_ready || bus.req1_ready || bus.rsp_valid) quiet = 1'b0;
                tick();
            end
            chk("rand.idle_quiet", 32'(quiet), 32'd1);
            p    = $urandom_range(1, 3);
            v0   = p[0];
            v1   = p[1];
            a0   = DW'($urandom);
            b0   = DW'($urandom);
            a1   = DW'($urandom);
            b1   = DW'($urandom);
            k    = $urandom_range(0, 22);
            hold = $urandom_range(0, 3);
            eid  = (v0 && v1) ? !lg : v1;
            ea   = eid ? a1 : a0;
            eb   = eid ? b1 : b0;
            eerr = (k == 0 || k + 1 > TMO);
            ey   = eerr ? '0 : RW'(ref_y(32'(ea), 32'(eb)));
            drive(v0, a0, b0, v1, a1, b1);
            run_txn($sformatf("rand%0d", it), eid, ea, eb, ey, eerr, k, hold);
            drive(1'b0, '0, '0, 1'b0, '0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
